store_data_narrower: RTL and testbench

STORE_DATA_NARROWER -- requirements
Module: store_data_narrower

---
 rtl/store_data_narrower_pkg.sv | 19 +
 rtl/store_lane_steer.sv | 38 +++
 rtl/store_data_narrower.sv | 99 +++++++++
 tb/tb_store_data_narrower.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/store_data_narrower_pkg.sv
// Shared pipeline definitions: store-mode encodings (also used by load extension),
// store FSM states and the exception counter width.
package store_data_narrower_pkg;

    typedef enum logic [1:0] {
        SM_BYTE = 2'b00,
        SM_HALF = 2'b01,
        SM_WORD = 2'b10,
        SM_ILL  = 2'b11
    } store_mode_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } store_state_e;

    localparam int EXC_CNT_W = 8;

endpackage

// File: rtl/store_lane_steer.sv
// Combinational lane steering: replicates store data across lanes, builds the
// byte strobe and flags misaligned or illegal store requests.
module store_lane_steer
    import store_data_narrower_pkg::*;
#(
    parameter int NB_DATA = 32
) (
    input  logic [NB_DATA-1:0] i_data,
    input  logic [1:0]         i_addr_lo,
    input  logic [1:0]         i_mode,
    output logic [NB_DATA-1:0] o_wdata,
    output logic [3:0]         o_wstrb,
    output logic               o_exc
);

    always_comb begin
        o_wdata = i_data;
        o_wstrb = 4'b0000;
        o_exc   = 1'b0;
        case (store_mode_e'(i_mode))
            SM_BYTE: begin
                o_wdata = {(NB_DATA/8){i_data[7:0]}};
                o_wstrb = 4'b0001 << i_addr_lo;
            end
            SM_HALF: begin
                o_wdata = {(NB_DATA/16){i_data[15:0]}};
                o_wstrb = i_addr_lo[1] ? 4'b1100 : 4'b0011;
                o_exc   = i_addr_lo[0];
            end
            SM_WORD: begin
                o_wstrb = 4'b1111;
                o_exc   = (i_addr_lo != 2'b00);
            end
            default: o_exc = 1'b1;
        endcase
    end

endmodule

// File: rtl/store_data_narrower.sv
// Store data narrower: accepts store requests, emits one registered memory write
// beat per legal store, and drops/counts misaligned or illegal ones.
module store_data_narrower
    import store_data_narrower_pkg::*;
#(
    parameter int NB_DATA = 32,
    parameter int NB_ADDR = 32
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [NB_DATA-1:0]   i_store_data,
    input  logic [NB_ADDR-1:0]   i_addr,
    input  logic [1:0]           i_store_mode,
    output logic                 o_mem_valid,
    input  logic                 i_mem_ready,
    output logic [NB_ADDR-1:0]   o_mem_addr,
    output logic [NB_DATA-1:0]   o_mem_wdata,
    output logic [3:0]           o_mem_wstrb,
    output logic                 o_exception,
    output logic [EXC_CNT_W-1:0] o_exc_count
);

    store_state_e         state_q, state_d;
    logic [NB_ADDR-1:0]   addr_q, addr_d;
    logic [NB_DATA-1:0]   wdata_q, wdata_d;
    logic [3:0]           wstrb_q, wstrb_d;
    logic                 exc_q, exc_d;
    logic [EXC_CNT_W-1:0] cnt_q, cnt_d;

    logic [NB_DATA-1:0]   steer_wdata;
    logic [3:0]           steer_wstrb;
    logic                 steer_exc;
    logic                 accept, legal;

    store_lane_steer #(.NB_DATA(NB_DATA)) u_steer (
        .i_data    (i_store_data),
        .i_addr_lo (i_addr[1:0]),
        .i_mode    (i_store_mode),
        .o_wdata   (steer_wdata),
        .o_wstrb   (steer_wstrb),
        .o_exc     (steer_exc)
    );

    // Reset gating keeps requests out while the block is held in reset.
    assign o_ready = i_reset_n && ((state_q == ST_IDLE) || i_mem_ready);
    assign accept  = i_valid && o_ready;
    assign legal   = accept && !steer_exc;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        exc_d   = accept && steer_exc;
        cnt_d   = cnt_q;
        if (accept && steer_exc && (cnt_q != {EXC_CNT_W{1'b1}}))
            cnt_d = cnt_q + 1'b1;
        case (state_q)
            ST_IDLE: if (legal) state_d = ST_HOLD;
            ST_HOLD: if (i_mem_ready) state_d = legal ? ST_HOLD : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (legal) begin
            addr_d  = {i_addr[NB_ADDR-1:2], 2'b00};
            wdata_d = steer_wdata;
            wstrb_d = steer_wstrb;
        end else if (state_d == ST_IDLE) begin
            wstrb_d = 4'b0000;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= 4'b0000;
            exc_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            exc_q   <= exc_d;
            cnt_q   <= cnt_d;
        end
    end

    assign o_mem_valid = (state_q == ST_HOLD);
    assign o_mem_addr  = addr_q;
    assign o_mem_wdata = wdata_q;
    assign o_mem_wstrb = wstrb_q;
    assign o_exception = exc_q;
    assign o_exc_count = cnt_q;

endmodule

// File: tb/tb_store_data_narrower.sv
// Directed-vector bench for store_data_narrower with hand-computed expectations.
module tb_store_data_narrower;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid;
    logic        ready;
    logic [31:0] sdata;
    logic [31:0] addr;
    logic [1:0]  mode;
    logic        mvalid;
    logic        mready;
    logic [31:0] maddr;
    logic [31:0] mwdata;
    logic [3:0]  mwstrb;
    logic        exc;
    logic [7:0]  exc_cnt;

    int vec_cnt = 0;
    int err_cnt = 0;

    always #5 clk = ~clk;

    store_data_narrower #(.NB_DATA(32), .NB_ADDR(32)) dut (
        .i_clk        (clk),
        .i_reset_n    (rst_n),
        .i_valid      (valid),
        .o_ready      (ready),
        .i_store_data (sdata),
        .i_addr       (addr),
        .i_store_mode (mode),
        .o_mem_valid  (mvalid),
        .i_mem_ready  (mready),
        .o_mem_addr   (maddr),
        .o_mem_wdata  (mwdata),
        .o_mem_wstrb  (mwstrb),
        .o_exception  (exc),
        .o_exc_count  (exc_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic req(input logic [1:0] m, input logic [31:0] a, input logic [31:0] d);
        valid = 1'b1;
        mode  = m;
        addr  = a;
        sdata = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; valid = 1'b0; mready = 1'b1;
        sdata = '0; addr = '0; mode = 2'b00;
        #12;
        chk("rst_ready", {31'b0, ready}, 32'd0);
        chk("rst_mvalid", {31'b0, mvalid}, 32'd0);
        chk("rst_wstrb", {28'b0, mwstrb}, 32'h0);
        chk("rst_cnt", {24'b0, exc_cnt}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_rst_ready", {31'b0, ready}, 32'd1);

        // byte store at 0x103
        tick();
        req(2'b00, 32'h103, 32'h0000_00A5);
        tick();
        chk("byte_valid", {31'b0, mvalid}, 32'd1);
        chk("byte_addr", maddr, 32'h100);
        chk("byte_wdata", mwdata, 32'hA5A5_A5A5);
        chk("byte_wstrb", {28'b0, mwstrb}, 32'h8);

        // halfword then word, back to back
        req(2'b01, 32'h202, 32'h1234_BEEF);
        tick();
        chk("half_wdata", mwdata, 32'hBEEF_BEEF);
        chk("half_wstrb", {28'b0, mwstrb}, 32'hC);
        chk("half_addr", maddr, 32'h200);
        req(2'b10, 32'h204, 32'hCAFE_F00D);
        tick();
        chk("word_valid", {31'b0, mvalid}, 32'd1);
        chk("word_wstrb", {28'b0, mwstrb}, 32'hF);
        chk("word_wdata", mwdata, 32'hCAFE_F00D);
        chk("word_addr", maddr, 32'h204);

        // backpressure: beat stable while mem not ready
        valid  = 1'b0;
        mready = 1'b0;
        #1;
        chk("bp_ready0", {31'b0, ready}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_valid", {31'b0, mvalid}, 32'd1);
            chk("bp_wdata", mwdata, 32'hCAFE_F00D);
            chk("bp_wstrb", {28'b0, mwstrb}, 32'hF);
            chk("bp_ready", {31'b0, ready}, 32'd0);
        end
        mready = 1'b1;
        #1;
        chk("drain_ready", {31'b0, ready}, 32'd1);
        tick();
        chk("drain_valid", {31'b0, mvalid}, 32'd0);
        chk("drain_wstrb", {28'b0, mwstrb}, 32'h0);

        // three exceptions
        req(2'b01, 32'h001, 32'h1111_1111);
        tick();
        chk("exc1_pulse", {31'b0, exc}, 32'd1);
        chk("exc1_mvalid", {31'b0, mvalid}, 32'd0);
        req(2'b10, 32'h006, 32'h2222_2222);
        tick();
        chk("exc2_pulse", {31'b0, exc}, 32'd1);
        chk("exc2_mvalid", {31'b0, mvalid}, 32'd0);
        req(2'b11, 32'h000, 32'h3333_3333);
        tick();
        chk("exc3_pulse", {31'b0, exc}, 32'd1);
        chk("exc3_mvalid", {31'b0, mvalid}, 32'd0);
        valid = 1'b0;
        tick();
        chk("exc_pulse_end", {31'b0, exc}, 32'd0);
        chk("exc_cnt3", {24'b0, exc_cnt}, 32'd3);

        // exception accepted while draining a held beat
        req(2'b00, 32'h012, 32'h0000_0077);
        tick();
        chk("drn_byte_wstrb", {28'b0, mwstrb}, 32'h4);
        req(2'b11, 32'h010, 32'h0);
        tick();
        chk("drn_exc_mvalid", {31'b0, mvalid}, 32'd0);
        chk("drn_exc_pulse", {31'b0, exc}, 32'd1);
        chk("drn_exc_cnt", {24'b0, exc_cnt}, 32'd4);
        valid  = 1'b0;
        mready = 1'b0;
        #1;
        chk("drn_idle_ready", {31'b0, ready}, 32'd1);
        mready = 1'b1;

        // saturation
        req(2'b11, 32'h0, 32'h0);
        for (int i = 0; i < 300; i++) tick();
        valid = 1'b0;
        tick();
        chk("sat_cnt", {24'b0, exc_cnt}, 32'd255);

        // async reset mid-HOLD
        mready = 1'b0;
        req(2'b10, 32'h300, 32'hDEAD_BEEF);
        tick();
        valid = 1'b0;
        chk("hold_valid", {31'b0, mvalid}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_mvalid", {31'b0, mvalid}, 32'd0);
        chk("arst_wstrb", {28'b0, mwstrb}, 32'h0);
        chk("arst_cnt", {24'b0, exc_cnt}, 32'd0);
        chk("arst_ready", {31'b0, ready}, 32'd0);
        chk("arst_addr", maddr, 32'h0);
        chk("arst_wdata", mwdata, 32'h0);
        tick();
        rst_n = 1'b1;
        mready = 1'b1;
        #1;
        chk("rel_ready", {31'b0, ready}, 32'd1);
        tick();
        chk("rel_no_replay", {31'b0, mvalid}, 32'd0);
        tick();
        chk("rel_no_replay2", {31'b0, mvalid}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
